// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the exhaustive 2:1 mux vector sequencer.
package mux_seq_pkg;

  localparam int NUM_VEC = 8;  // every {a, b, c} combination
  localparam int VEC_W   = 3;  // width of a vector index
  localparam int TMR_W   = 4;  // width of the settle/hold down-counter

  // Sequencer states; the encoding is also visible on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Reference behaviour of the mux under test: c selects b, otherwise a.
  function automatic logic mux_exp(input logic a, input logic b, input logic c);
    return c ? b : a;
  endfunction

endpackage

// File: rtl/cyc_timer.sv
// Loadable down-counter used for both the settle window and the hold window.
// Load wins over counting; the counter parks at zero until reloaded.
module cyc_timer
  import mux_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [TMR_W-1:0] cnt_q;

  // Count register: reload on request, otherwise decrement while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TMR_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_vec_sequencer.sv
// Exhaustive stimulus/check stage for a 2:1 mux. Walks the 8 vectors in
// binary order, waits a settle window, samples y_in, optionally holds the
// vector, and accumulates an error count plus the first failing index.
//
// Control handshake: start is a level request honoured only in IDLE or DONE
// (start together with abort in IDLE is ignored); abort is honoured only in
// the busy states (SETTLE, SAMPLE, HOLD) and beats any simultaneous timer
// expiry or sample, so an aborted SAMPLE edge is never scored.
module mux_vec_sequencer
  import mux_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 1,   // 1..15
  parameter int HOLD_CYC   = 10   // 0..15, 0 = no hold phase
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       mismatch,
  output logic [3:0] err_cnt,
  output logic [2:0] first_fail,
  output logic       fail_seen,
  output logic [2:0] dbg_state
);

  localparam logic             HAS_HOLD  = (HOLD_CYC > 0);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'((HOLD_CYC > 0) ? (HOLD_CYC - 1) : 0);

  state_t           state_q;
  logic [VEC_W-1:0] vec_idx_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             mismatch_q;
  logic [3:0]       err_cnt_q;
  logic [3:0]       err_cnt_d;
  logic [VEC_W-1:0] first_fail_q;
  logic             fail_seen_q;

  logic             last_vec;
  logic             exp_y;
  logic             sample_bad;
  logic             tmr_zero;
  logic             tmr_load;
  logic             tmr_en;
  logic [TMR_W-1:0] tmr_val;

  // The mux inputs are the bits of the applied index, so they are registered.
  assign a_out     = vec_idx_q[2];
  assign b_out     = vec_idx_q[1];
  assign c_out     = vec_idx_q[0];
  assign vec_idx   = vec_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign mismatch  = mismatch_q;
  assign err_cnt   = err_cnt_q;
  assign first_fail = first_fail_q;
  assign fail_seen = fail_seen_q;
  assign dbg_state = state_q;

  assign last_vec   = (vec_idx_q == VEC_W'(NUM_VEC - 1));
  assign exp_y      = mux_exp(a_out, b_out, c_out);
  assign sample_bad = (state_q == ST_SAMPLE) && !abort && (y_in != exp_y);
  assign err_cnt_d  = err_cnt_q + {3'b000, sample_bad};

  // Timer loads on every edge that enters SETTLE or HOLD; it counts in both.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = SETTLE_LD;
    case (state_q)
      ST_IDLE:   tmr_load = start && !abort;
      ST_DONE:   tmr_load = start;
      ST_SAMPLE: begin
        if (!abort) begin
          if (HAS_HOLD) begin
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
          end else begin
            tmr_load = !last_vec;
          end
        end
      end
      ST_HOLD:   tmr_load = !abort && tmr_zero && !last_vec;
      default:   tmr_load = 1'b0;
    endcase
  end

  assign tmr_en = (state_q == ST_SETTLE) || (state_q == ST_HOLD);

  cyc_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  // Sequencer FSM with all status outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vec_idx_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      mismatch_q   <= 1'b0;
      err_cnt_q    <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
    end else begin
      mismatch_q <= sample_bad;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && ((state_q == ST_DONE) || !abort)) begin
            state_q      <= ST_SETTLE;
            vec_idx_q    <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
          end
        end

        ST_SETTLE: begin
          if (abort) begin
            state_q   <= ST_IDLE;
            vec_idx_q <= '0;
            busy_q    <= 1'b0;
          end else if (tmr_zero) begin
            state_q <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          if (abort) begin
            state_q   <= ST_IDLE;
            vec_idx_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            err_cnt_q <= err_cnt_d;
            if (sample_bad && !fail_seen_q) begin
              fail_seen_q  <= 1'b1;
              first_fail_q <= vec_idx_q;
            end
            if (HAS_HOLD) begin
              state_q <= ST_HOLD;
            end else if (last_vec) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_d == 4'd0);
            end else begin
              state_q   <= ST_SETTLE;
              vec_idx_q <= vec_idx_q + VEC_W'(1);
            end
          end
        end

        ST_HOLD: begin
          if (abort) begin
            state_q   <= ST_IDLE;
            vec_idx_q <= '0;
            busy_q    <= 1'b0;
          end else if (tmr_zero) begin
            if (last_vec) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_q == 4'd0);
            end else begin
              state_q   <= ST_SETTLE;
              vec_idx_q <= vec_idx_q + VEC_W'(1);
            end
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          vec_idx_q <= '0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          pass_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_vec_sequencer.md
Name: mux_vec_sequencer

Overview:
- Self-checking stimulus stage that sits directly upstream of the 2:1 mux (a, b, select c; output y) and consumes the mux output.
- Steps all 8 input combinations in binary order, drives them onto the mux and samples y after a settle window.
- Compares each sample against y = c ? b : a, then reports an error count, the first failing vector and pass/done status.
- Serves as the hardware replacement for the hand-written exhaustive mux benches in the datapath labs.

Parameters:
- SETTLE_CYC, 1, cycles between driving a vector and sampling y_in (legal range 1..15).
- HOLD_CYC, 10, cycles a vector stays applied after sampling (legal range 0..15; 0 means no hold).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level-sampled run request; acted on only in IDLE or DONE.
- abort  in  1  synchronous abort; returns to IDLE from any busy state.
- y_in  in  1  mux output being checked.
- a_out  out  1  mux data input a; equals vec_idx[2].
- b_out  out  1  mux data input b; equals vec_idx[1].
- c_out  out  1  mux select c; equals vec_idx[0].
- vec_idx  out  3  index of the vector currently applied.
- busy  out  1  high in SETTLE, SAMPLE and HOLD.
- done  out  1  high in DONE; stays high until the next start or reset.
- pass  out  1  high in DONE only when err_cnt == 0.
- mismatch  out  1  one-cycle pulse on the cycle after a failing sample.
- err_cnt  out  4  count of failing vectors (0..8); no saturation needed.
- first_fail  out  3  index of the first failing vector; valid only when fail_seen = 1.
- fail_seen  out  1  set by the first mismatch of a run.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE.
  - Every output = 0, including a/b/c, vec_idx, err_cnt, first_fail and all flags.
  - Takes effect immediately, including mid-run.
- States: IDLE, SETTLE, SAMPLE, HOLD, DONE.
- IDLE:
  - a/b/c_out = 0, busy = 0.
  - start = 1 -> SETTLE with vec_idx = 0 and a/b/c driven from index 0.
  - The same start edge clears err_cnt, fail_seen, first_fail and done.
- SETTLE:
  - busy = 1.
  - A timer loads SETTLE_CYC-1 on entry and counts down.
  - When the timer reaches 0 -> SAMPLE.
- SAMPLE (exactly 1 cycle):
  - At its closing edge, y_in is compared against exp = c_out ? b_out : a_out.
  - On mismatch: err_cnt += 1 and mismatch = 1 for the next cycle.
  - On the first mismatch of the run, also set fail_seen = 1 and first_fail = vec_idx.
  - Next state:
    - HOLD_CYC > 0 -> HOLD.
    - Else if vec_idx == 7 -> DONE.
    - Else -> SETTLE with vec_idx + 1 and outputs updated on that same edge.
- HOLD:
  - The timer loads HOLD_CYC-1 and counts down.
  - At 0: vec_idx == 7 -> DONE, else -> SETTLE with vec_idx + 1.
- Vector period = SETTLE_CYC + 1 + HOLD_CYC cycles.
- Full run = 8 × period; done rises 8 × period edges after the start edge.
- DONE:
  - busy = 0, done = 1, pass = (err_cnt == 0).
  - a/b/c_out keep vector 7.
  - start = 1 -> restart exactly as from IDLE.
- start while busy is ignored, so start held high does not retrigger until DONE.
- abort = 1 in a busy state:
  - Next edge -> IDLE; a/b/c_out and vec_idx = 0, done = 0, pass = 0.
  - err_cnt, fail_seen and first_fail are retained.
- abort has priority over a simultaneous timer expiry; a SAMPLE edge coinciding with abort does not count.
- abort in IDLE or DONE has no effect; start and abort together in IDLE -> remain IDLE.
- vec_idx never wraps: after index 7 the block always goes to DONE.

Decomposition:
- Shared package mux_seq_pkg holds:
  - the state enum (5 states);
  - NUM_VEC = 8, VEC_W = 3, TMR_W = 4;
  - function mux_exp(a, b, c) returning c ? b : a.
- One sub-module, cyc_timer:
  - TMR_W-bit loadable down-counter with load and zero flag;
  - shared by SETTLE and HOLD;
  - same clk/rst_n convention.

Test Plan:
- Correct mux, SETTLE=1, HOLD=0, start pulse:
  - Run covers indices 0..7 with c_out toggling every 2 cycles.
  - done rises 16 cycles after the start edge with err_cnt = 0, pass = 1, fail_seen = 0.
- y_in stuck at 0, defaults (period 12):
  - Mismatches at indices 3, 4, 6, 7.
  - err_cnt = 4, first_fail = 3, pass = 0, 4 mismatch pulses; done at cycle 96.
- y_in = ~expected:
  - err_cnt = 8, first_fail = 0.
  - Then a second start after done clears the counters and reruns (correct mux) to pass = 1.
- abort while vec_idx = 4:
  - IDLE next edge, a/b/c = 0, done = 0, err_cnt retained.
  - A new start restarts from index 0 with err_cnt = 0.
- rst_n pulled low mid-HOLD, between clock edges:
  - All outputs 0 before the next edge.
  - After release, no activity until start.
- start held high through the run:
  - No retrigger while busy.
  - The DONE state is visible for exactly 1 cycle, then the next run starts.
